// File: rtl/rsa_mont_mult_if.sv
// Operand/result bundle for the radix-2 Montgomery multiplier.
// The master side issues start with operands; the slave side returns the
// result, the completion pulse and the busy flag.
interface rsa_mont_mult_if #(
  parameter int unsigned WIDTH = 256
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] o_m;
  logic             o_finished;
  logic             o_busy;

  modport master (
    output i_start, i_a, i_b, i_n,
    input  o_m, o_finished, o_busy
  );

  modport slave (
    input  i_start, i_a, i_b, i_n,
    output o_m, o_finished, o_busy
  );
endinterface

// File: rtl/rsa_mont_mult.sv
// Radix-2 Montgomery multiplier: o_m = a * b * 2^-WIDTH mod n.
// One multiplier bit is consumed per cycle (WIDTH cycles), followed by a
// single conditional-subtract cycle. Operands are captured at start, so the
// caller may change its inputs while the operation runs.
module rsa_mont_mult #(
  parameter int unsigned WIDTH = 256
) (
  input logic          i_clk,
  input logic          i_rst,
  rsa_mont_mult_if.slave bus
);
  localparam int unsigned KW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  // Accumulator stays below 2n; the intermediate sum stays below 4n, so two
  // guard bits above WIDTH keep every carry.
  logic [WIDTH+1:0] m_q;
  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_red;
  logic [WIDTH-1:0] m_out;
  logic             fin_q;

  // One Montgomery step: add a if the current multiplier bit is set, then
  // add n if needed to make the sum even so the halving is exact.
  always_comb begin
    t_add = m_q + (b_q[k] ? {2'b00, a_q} : '0);
    t_red = t_add + (t_add[0] ? {2'b00, n_q} : '0);
  end

  // Control FSM, operand capture, iteration and final reduction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      k     <= '0;
      m_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      m_out <= '0;
      fin_q <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            a_q   <= bus.i_a;
            b_q   <= bus.i_b;
            n_q   <= bus.i_n;
            m_q   <= '0;
            k     <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          m_q <= t_red >> 1;
          k   <= k + 1'b1;
          if (k == KW'(WIDTH - 1)) begin
            state <= S_FINAL;
          end
        end
        S_FINAL: begin
          m_out <= WIDTH'((m_q >= {2'b00, n_q}) ? (m_q - {2'b00, n_q}) : m_q);
          fin_q <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Busy covers the iteration and the final-subtract cycles.
  always_comb begin
    bus.o_m        = m_out;
    bus.o_finished = fin_q;
    bus.o_busy     = (state != S_IDLE);
  end
endmodule

// File: tb/tb_rsa_mont_mult.sv
// Self-checking bench for rsa_mont_mult against a word-level REDC model.
module tb_rsa_mont_mult;
  localparam int unsigned W = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rsa_mont_mult_if #(.WIDTH(W)) bus ();
  rsa_mont_mult #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // a*b*R^-1 mod n via REDC with q = -T * n^-1 mod R (Newton inverse).
  function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] n);
    logic [W-1:0]     inv;
    logic [W-1:0]     q;
    logic [2*W-1:0]   t;
    logic [2*W+1:0]   s;
    inv = n;
    for (int i = 0; i < 8; i++) inv = inv * (256'd2 - n * inv);
    t = {256'b0, a} * {256'b0, b};
    q = (256'd0 - t[W-1:0]) * inv;
    s = {2'b00, t} + {258'b0, q} * {258'b0, n};
    s = s >> W;
    if (s >= {258'b0, n}) s = s - {258'b0, n};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[W-33:0], $urandom()};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation and waits (bounded) for o_finished.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n,
                        output logic [W-1:0] res, output int lat,
                        output logic busy_mid, output logic busy_fin);
    bus.i_a = a; bus.i_b = b; bus.i_n = n; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    lat = 0; res = '0; busy_mid = 1'b0; busy_fin = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (c == 128) busy_mid = bus.o_busy;
      if (bus.o_finished) begin
        lat = c; res = bus.o_m; busy_fin = bus.o_busy;
        break;
      end
    end
  endtask

  logic [W-1:0] ra, rb, rn, res, r1, r2, a2, b2, n2;
  logic         bmid, bfin;
  int           lat, lat1, lat2, fin_cnt, hold_err;

  logic [W-1:0] dn [3] = '{256'd13, 256'd13, 256'd13};
  logic [W-1:0] da [3] = '{256'd1,  256'd3,  256'd0};
  logic [W-1:0] db [3] = '{256'd1,  256'd5,  256'd12};
  logic [W-1:0] de [3] = '{256'd9,  256'd5,  256'd0};

  initial begin
    rst = 1'b1; bus.i_start = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_n = '0;
    tick(); tick();
    check("rst_m", bus.o_m, '0);
    check("rst_fin", W'(bus.o_finished), '0);
    check("rst_busy", W'(bus.o_busy), '0);
    rst = 1'b0;
    tick();

    // Directed small-modulus vectors.
    for (int i = 0; i < 3; i++) begin
      run_op(da[i], db[i], dn[i], res, lat, bmid, bfin);
      check("dir_res", res, de[i]);
      check("dir_lat", W'(lat), W'(257));
      check("dir_busy_mid", W'(bmid), W'(1));
      check("dir_busy_fin", W'(bfin), '0);
      tick();
      check("dir_one_pulse", W'(bus.o_finished), '0);
      check("dir_hold", bus.o_m, de[i]);
    end

    // Largest modulus, largest operands.
    rn = '1; ra = rn - 1'b1;
    run_op(ra, ra, rn, res, lat, bmid, bfin);
    check("max_res", res, mont_ref(ra, ra, rn));
    check("max_lat", W'(lat), W'(257));
    tick();

    // Random odd-modulus, in-range vectors.
    for (int i = 0; i < 60; i++) begin
      rn = rand256();
      rn[0] = 1'b1;
      if (i % 4 == 0) rn[W-1] = 1'b1;
      if (rn == 256'd1) rn = 256'd3;
      ra = rand256() % rn;
      rb = rand256() % rn;
      run_op(ra, rb, rn, res, lat, bmid, bfin);
      check("rnd_res", res, mont_ref(ra, rb, rn));
      if (lat != 257) check("rnd_lat", W'(lat), W'(257));
      tick();
    end

    // Start re-pulsed while busy and on the finishing edge; i_a changed after E0.
    bus.i_a = 256'd7; bus.i_b = 256'd9; bus.i_n = 256'd13; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0; bus.i_a = 256'd2;
    fin_cnt = 0; lat = 0; res = '0;
    for (int c = 1; c <= 300; c++) begin
      bus.i_start = (c == 10 || c == 257);
      tick();
      if (bus.o_finished) begin fin_cnt++; lat = c; res = bus.o_m; end
    end
    bus.i_start = 1'b0;
    check("ign_count", W'(fin_cnt), W'(1));
    check("ign_lat", W'(lat), W'(257));
    check("ign_res", res, mont_ref(256'd7, 256'd9, 256'd13));
    check("ign_busy", W'(bus.o_busy), '0);

    // Reset at E100 aborts the operation.
    bus.i_a = 256'd5; bus.i_b = 256'd6; bus.i_n = 256'd13; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      rst = (c == 100);
      tick();
    end
    check("abort_busy", W'(bus.o_busy), '0);
    check("abort_m", bus.o_m, '0);
    check("abort_fin", W'(bus.o_finished), '0);
    rst = 1'b0;
    fin_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (bus.o_finished) fin_cnt++;
    end
    check("abort_no_pulse", W'(fin_cnt), '0);
    rn = rand256(); rn[0] = 1'b1; rn[W-1] = 1'b1;
    ra = rand256() % rn; rb = rand256() % rn;
    run_op(ra, rb, rn, res, lat, bmid, bfin);
    check("post_rst_res", res, mont_ref(ra, rb, rn));
    check("post_rst_lat", W'(lat), W'(257));
    tick();

    // Back-to-back: second start sampled at E258.
    rn = rand256(); rn[0] = 1'b1;
    ra = rand256() % rn; rb = rand256() % rn;
    n2 = rand256(); n2[0] = 1'b1; n2[W-1] = 1'b1;
    a2 = rand256() % n2; b2 = rand256() % n2;
    bus.i_a = ra; bus.i_b = rb; bus.i_n = rn; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    lat1 = 0; lat2 = 0; r1 = '0; r2 = '0; hold_err = 0; fin_cnt = 0;
    for (int c = 1; c <= 540; c++) begin
      bus.i_start = (c == 258);
      if (c == 258) begin bus.i_a = a2; bus.i_b = b2; bus.i_n = n2; end
      tick();
      if (bus.o_finished) begin
        fin_cnt++;
        if (fin_cnt == 1) begin lat1 = c; r1 = bus.o_m; end
        else begin lat2 = c; r2 = bus.o_m; end
      end
      if (c >= 258 && c <= 514 && bus.o_m !== r1) hold_err++;
    end
    bus.i_start = 1'b0;
    check("b2b_lat1", W'(lat1), W'(257));
    check("b2b_lat2", W'(lat2), W'(515));
    check("b2b_res1", r1, mont_ref(ra, rb, rn));
    check("b2b_res2", r2, mont_ref(a2, b2, n2));
    check("b2b_hold", W'(hold_err), '0);
    check("b2b_count", W'(fin_cnt), W'(2));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
